// File: rtl/layer_ctrl_if.sv
// layer_ctrl_if: handshake/bus bundle between the layer sequencer and its datapath.
//   start    : run request (datapath/host -> controller)
//   abort    : run abort, present only when LAYER_CTRL_ABORT_EN is defined
//   busy     : controller not idle
//   done     : one-cycle run-complete pulse
//   mem_rd   : weight-memory read strobe (shared by all banks)
//   mem_addr : weight address g*L + i
//   in_idx   : input-vector index aligned with mem_rd
//   mac_en   : MAC operand valid (mem_rd delayed one cycle)
//   mac_idx  : in_idx delayed one cycle
//   mac_clr  : accumulator clear pulse
//   out_we   : output-layer write strobe
//   out_grp  : group index qualified by out_we
// Modport master is the controller side, slave is the datapath side.
`timescale 1ns / 1ps

interface layer_ctrl_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned IW = 10,
    parameter int unsigned GW = 3
);
    logic          start;
`ifdef LAYER_CTRL_ABORT_EN
    logic          abort;
`endif
    logic          busy;
    logic          done;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] in_idx;
    logic          mac_en;
    logic [IW-1:0] mac_idx;
    logic          mac_clr;
    logic          out_we;
    logic [GW-1:0] out_grp;

    modport master (
        input  start,
`ifdef LAYER_CTRL_ABORT_EN
        input  abort,
`endif
        output busy, done, mem_rd, mem_addr, in_idx,
        output mac_en, mac_idx, mac_clr, out_we, out_grp
    );

    modport slave (
        output start,
`ifdef LAYER_CTRL_ABORT_EN
        output abort,
`endif
        input  busy, done, mem_rd, mem_addr, in_idx,
        input  mac_en, mac_idx, mac_clr, out_we, out_grp
    );
endinterface

// File: rtl/layer_ctrl.sv
// layer_ctrl: sequences G neuron groups of L MAC terms each over a shared MAC array.
// Per group: CLEAR (1) -> ISSUE (L) -> DRAIN (MAC_LAT+1) -> WRITE (1); DONE (1) after the last.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : layer_ctrl_if.master (start/abort in, strobes, addresses and indices out)
// Optional feature: define LAYER_CTRL_ABORT_EN to add bus.abort, which returns the
// controller to IDLE from any busy state and clears the accumulators on the next cycle.
`timescale 1ns / 1ps

module layer_ctrl #(
    parameter int unsigned L       = 784,
    parameter int unsigned G       = 5,
    parameter int unsigned MAC_LAT = 2
) (
    input logic         clk,
    input logic         rst,
    layer_ctrl_if.master bus
);
    localparam int unsigned AW = $clog2(G * L);
    localparam int unsigned IW = $clog2(L);
    localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
    // Drain counter counts 0..MAC_LAT
    localparam int unsigned DW = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StIssue,
        StDrain,
        StWrite,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] g_q, g_d;
    logic [IW-1:0] i_q, i_d;
    logic [AW-1:0] base_q, base_d;   // g*L, stepped by L per group to avoid a multiplier
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          mac_en_q;
    logic [IW-1:0] mac_idx_q;
`ifdef LAYER_CTRL_ABORT_EN
    logic          abort_hit;
    logic          abort_clr_q;
`endif

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        i_d          = i_q;
        base_d       = base_q;
        dcnt_d       = dcnt_q;
        bus.busy     = (state_q != StIdle);
        bus.done     = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_addr = '0;
        bus.in_idx   = '0;
        bus.mac_clr  = 1'b0;
        bus.out_we   = 1'b0;
        bus.out_grp  = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StClear;
                    g_d     = '0;
                    base_d  = '0;
                end
            end
            StClear: begin
                bus.mac_clr = 1'b1;
                i_d         = '0;
                state_d     = StIssue;
            end
            StIssue: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = base_q + AW'(i_q);
                bus.in_idx   = i_q;
                if (i_q == IW'(L - 1)) begin
                    // i holds at L-1 through DRAIN; CLEAR rewinds it
                    state_d = StDrain;
                    dcnt_d  = '0;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            StDrain: begin
                if (dcnt_q == DW'(MAC_LAT)) begin
                    state_d = StWrite;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            StWrite: begin
                bus.out_we  = 1'b1;
                bus.out_grp = g_q;
                if (g_q == GW'(G - 1)) begin
                    state_d = StDone;
                end else begin
                    g_d     = g_q + GW'(1);
                    base_d  = base_q + AW'(L);
                    state_d = StClear;
                end
            end
            StDone: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef LAYER_CTRL_ABORT_EN
        abort_hit = bus.abort && (state_q != StIdle);
        if (abort_hit) begin
            state_d = StIdle;
            g_d     = '0;
            i_d     = '0;
            base_d  = '0;
            dcnt_d  = '0;
        end
        // Accumulators are cleared in the first IDLE cycle after an abort
        bus.mac_clr = bus.mac_clr | abort_clr_q;
`endif
        bus.mac_en  = mac_en_q;
        bus.mac_idx = mac_idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            g_q         <= '0;
            i_q         <= '0;
            base_q      <= '0;
            dcnt_q      <= '0;
            mac_en_q    <= 1'b0;
            mac_idx_q   <= '0;
`ifdef LAYER_CTRL_ABORT_EN
            abort_clr_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            i_q         <= i_d;
            base_q      <= base_d;
            dcnt_q      <= dcnt_d;
`ifdef LAYER_CTRL_ABORT_EN
            abort_clr_q <= abort_hit;
            mac_en_q    <= bus.mem_rd & ~abort_hit;
            mac_idx_q   <= abort_hit ? '0 : bus.in_idx;
`else
            // in_idx is already 0 when mem_rd is low, so mac_idx follows the same rule
            mac_en_q    <= bus.mem_rd;
            mac_idx_q   <= bus.in_idx;
`endif
        end
    end
endmodule

// File: doc/layer_ctrl.md
LAYER_CTRL -- requirements
Module: layer_ctrl

Interface
REQ-001 SHALL have parameter L, default 784: inputs per neuron, i.e. MAC terms per group.
REQ-002 SHALL have parameter G, default 5: neuron groups processed sequentially on the shared MAC array.
REQ-003 SHALL have parameter MAC_LAT, default 2: MAC pipeline latency in cycles, minimum 1.
REQ-004 SHALL derive AW = $clog2(G*L), IW = $clog2(L), GW = max(1, $clog2(G)).
REQ-005 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-007 SHALL have port start  in  1: run request, sampled only in IDLE.
REQ-008 SHALL have port busy  out  1: high in every state except IDLE.
REQ-009 SHALL have port done  out  1: one-cycle pulse at run completion.
REQ-010 SHALL have port mem_rd  out  1: weight-memory read strobe, shared by all N banks.
REQ-011 SHALL have port mem_addr  out  AW: weight address, g*L + i.
REQ-012 SHALL have port in_idx  out  IW: input-vector index, aligned with mem_rd.
REQ-013 SHALL have port mac_en  out  1: MAC operand-valid, mem_rd delayed one cycle.
REQ-014 SHALL have port mac_idx  out  IW: in_idx delayed one cycle, selecting the input that pairs with the memory q.
REQ-015 SHALL have port mac_clr  out  1: accumulator clear pulse.
REQ-016 SHALL have port out_we  out  1: one-cycle strobe latching MAC results into the output layer.
REQ-017 SHALL have port out_grp  out  GW: group index qualified by out_we.

Function
REQ-018 SHALL implement states IDLE, CLEAR, ISSUE, DRAIN, WRITE, DONE.
REQ-019 SHALL go IDLE->CLEAR when start=1 in IDLE, with g=0; start SHALL be ignored in all other states.
REQ-020 SHALL assert mac_clr for exactly the one CLEAR cycle, then enter ISSUE with i=0.
REQ-021 SHALL hold ISSUE exactly L cycles: mem_rd=1, mem_addr=g*L+i, in_idx=i, with i incrementing 0..L-1 and no gaps.
REQ-022 SHALL make mac_en/mac_idx registered copies of mem_rd/in_idx, giving a fixed weight-memory read latency of 1.
REQ-023 SHALL hold DRAIN exactly MAC_LAT+1 cycles, with mem_rd=0 and the counter frozen.
REQ-024 SHALL spend one cycle in WRITE with out_we=1 and out_grp=g, then go to CLEAR with g+1 if g<G-1, else to DONE.
REQ-025 SHALL pulse done=1 for the one DONE cycle, then return to IDLE; busy SHALL fall in the same cycle as the return to IDLE.
REQ-026 SHALL take L+MAC_LAT+3 cycles per group; done SHALL occur G*(L+MAC_LAT+3)+1 cycles after the start sample edge.
REQ-027 SHALL drive mem_addr, in_idx and mac_idx to 0 whenever their strobe is low.
REQ-028 SHALL handle i wrap at L-1 and the g*L+i arithmetic in AW bits without overflow, for L not a power of two.
REQ-029 SHALL accept start held high through DONE as a new run starting from IDLE on the following cycle; there SHALL be no back-to-back CLEAR from DONE.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, go to IDLE with g=0, i=0, and all outputs 0, including the mac_en/mac_idx pipeline.
REQ-031 SHALL, on rst mid-run, not emit out_we or done, and SHALL take priority over start and abort.

Configuration
REQ-032 SHALL, with LAYER_CTRL_ABORT_EN defined, add input abort (1 bit), priority over all state transitions except rst.
REQ-033 SHALL, with LAYER_CTRL_ABORT_EN defined, on abort=1 in any non-IDLE state, enter IDLE next cycle and force mem_rd, mac_en, out_we and done to 0 from that cycle.
REQ-034 SHALL, with LAYER_CTRL_ABORT_EN defined, assert mac_clr for one cycle on the cycle following abort.
REQ-035 SHALL, with LAYER_CTRL_ABORT_EN defined, ignore abort in IDLE.
REQ-036 SHALL, without LAYER_CTRL_ABORT_EN, have no abort port and behave exactly as REQ-018..REQ-031.

Verification (L=4, G=2, MAC_LAT=2; cycle 0 = start sample edge)
REQ-037 SHALL cover a full run -> mac_clr at 1 and 10; mem_rd 2-5 with addr 0,1,2,3 and 11-14 with addr 4,5,6,7; out_we at 9 (grp 0) and 18 (grp 1); done at 19; busy 1-19.
REQ-038 SHALL cover alignment -> mac_en 3-6 with mac_idx 0,1,2,3, each equal to the prior cycle's in_idx.
REQ-039 SHALL cover start pulsed at cycles 5 and 12 -> no effect on the run; held high through 19 -> new run with CLEAR at 21.
REQ-040 SHALL cover rst at cycle 7 -> all outputs 0 at 8; no out_we or done; a later start runs normally from addr 0.
REQ-041 SHALL cover, with LAYER_CTRL_ABORT_EN, abort at cycle 12 -> IDLE and busy=0 at 13, mac_clr=1 at 13, no out_we for grp 1 and no done.
REQ-042 SHALL cover L=3, G=3 -> mem_addr sequence 0..8 contiguous; done at cycle 3*(3+2+3)+1=25.
